// File: rtl/viterbi_pkg.sv
// Shared constants and scheduler state encoding for the K=7 rate-1/2 Viterbi path.
package viterbi_pkg;

    localparam int FRAME_CODED         = 48;
    localparam int FRAME_DATA          = 24;
    localparam int DEC_LATENCY_DEFAULT = 26;

    // Write pointer covers 0..FRAME_CODED-1; the feed index also needs FRAME_CODED itself.
    localparam int IDX_W    = $clog2(FRAME_CODED);
    localparam int RD_IDX_W = $clog2(FRAME_CODED + 1);

    typedef enum logic [2:0] {
        ST_SYNC,
        ST_IDLE,
        ST_FEED,
        ST_WAIT,
        ST_CAPTURE,
        ST_HOLD
    } sched_state_t;

endpackage

// File: rtl/coded_frame_buffer.sv
// Two-bank ping-pong store for coded frames: write pointer, full flags, read-bit mux.
module coded_frame_buffer
    import viterbi_pkg::*;
(
    input  logic                Clk,
    input  logic                reset,
    input  logic                wr_valid,
    input  logic                wr_bit,
    output logic                wr_ready,
    input  logic [RD_IDX_W-1:0] rd_idx,
    input  logic                rd_free,
    output logic                rd_full,
    output logic                rd_bit
);

    logic [1:0][FRAME_CODED-1:0] mem;
    logic [1:0]                  full;
    logic [1:0]                  full_nxt;
    logic                        wr_bank;
    logic                        rd_bank;
    logic [IDX_W-1:0]            wr_ptr;
    logic                        wr_fire;
    logic                        wr_last;

    assign wr_fire = wr_valid && wr_ready;
    assign wr_last = wr_fire && (wr_ptr == IDX_W'(FRAME_CODED - 1));
    assign rd_full = full[rd_bank];
    assign rd_bit  = (rd_idx < RD_IDX_W'(FRAME_CODED)) ? mem[rd_bank][rd_idx] : 1'b0;

    // Next full flags: a free of the read bank and a fill of the write bank can land together.
    always_comb begin
        full_nxt = full;
        if (rd_free) full_nxt[rd_bank] = 1'b0;
        if (wr_last) full_nxt[wr_bank] = 1'b1;
    end

    // Bank storage, pointers and a registered ready that looks at the post-edge write bank.
    always_ff @(posedge Clk or negedge reset) begin
        if (!reset) begin
            mem      <= '0;
            full     <= '0;
            wr_bank  <= 1'b0;
            rd_bank  <= 1'b0;
            wr_ptr   <= '0;
            wr_ready <= 1'b0;
        end else begin
            full     <= full_nxt;
            wr_ready <= !full_nxt[wr_bank ^ wr_last];
            if (wr_fire) begin
                mem[wr_bank][wr_ptr] <= wr_bit;
                wr_ptr <= wr_last ? '0 : wr_ptr + IDX_W'(1);
            end
            if (wr_last) wr_bank <= ~wr_bank;
            if (rd_free) rd_bank <= ~rd_bank;
        end
    end

endmodule

// File: rtl/viterbi_frame_ctrl.sv
// Frame scheduler: buffers coded bits, bursts each frame into the decoder,
// waits out the decoder latency, captures the decoded word and hands it downstream.
module viterbi_frame_ctrl
    import viterbi_pkg::*;
#(
    parameter int DEC_LATENCY = DEC_LATENCY_DEFAULT,
    parameter int CNT_W       = 16
) (
    input  logic                  Clk,
    input  logic                  reset,
    input  logic                  s_bit,
    input  logic                  s_valid,
    output logic                  s_ready,
    output logic                  dec_reset,
    output logic                  dec_in,
    output logic                  dec_valid_in,
    input  logic                  dec_out,
    output logic [FRAME_DATA-1:0] m_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic                  busy,
    output logic [CNT_W-1:0]      frame_cnt
);

    // One phase counter serves SYNC, WAIT and CAPTURE; size it for the longest of them.
    localparam int PH_MAX = (DEC_LATENCY > FRAME_DATA) ? DEC_LATENCY : FRAME_DATA;
    localparam int PH_W   = $clog2(PH_MAX + 1);

    sched_state_t        state;
    logic [RD_IDX_W-1:0] feed_idx;
    logic [PH_W-1:0]     ph_cnt;
    logic                rd_free;
    logic                rd_full;
    logic                rd_bit;

    // feed_idx runs one ahead of the bit on dec_in; reaching FRAME_CODED means bit 47 is out.
    assign rd_free = (state == ST_FEED) && (feed_idx == RD_IDX_W'(FRAME_CODED));

    coded_frame_buffer u_buf (
        .Clk      (Clk),
        .reset    (reset),
        .wr_valid (s_valid),
        .wr_bit   (s_bit),
        .wr_ready (s_ready),
        .rd_idx   (feed_idx),
        .rd_free  (rd_free),
        .rd_full  (rd_full),
        .rd_bit   (rd_bit)
    );

    // Scheduler FSM with all decoder-side and downstream outputs registered.
    always_ff @(posedge Clk or negedge reset) begin
        if (!reset) begin
            state        <= ST_SYNC;
            feed_idx     <= '0;
            ph_cnt       <= '0;
            dec_reset    <= 1'b0;
            dec_in       <= 1'b0;
            dec_valid_in <= 1'b0;
            m_data       <= '0;
            m_valid      <= 1'b0;
            busy         <= 1'b0;
            frame_cnt    <= '0;
        end else begin
            case (state)
                ST_SYNC: begin
                    if (ph_cnt == PH_W'(1)) begin
                        ph_cnt    <= '0;
                        dec_reset <= 1'b1;
                        state     <= ST_IDLE;
                    end else begin
                        ph_cnt <= ph_cnt + PH_W'(1);
                    end
                end
                ST_IDLE: begin
                    if (rd_full) begin
                        state        <= ST_FEED;
                        busy         <= 1'b1;
                        dec_valid_in <= 1'b1;
                        dec_in       <= rd_bit;
                        feed_idx     <= RD_IDX_W'(1);
                    end
                end
                ST_FEED: begin
                    if (rd_free) begin
                        state        <= ST_WAIT;
                        dec_valid_in <= 1'b0;
                        dec_in       <= 1'b0;
                        feed_idx     <= '0;
                    end else begin
                        dec_in   <= rd_bit;
                        feed_idx <= feed_idx + RD_IDX_W'(1);
                    end
                end
                ST_WAIT: begin
                    if (ph_cnt == PH_W'(DEC_LATENCY - 1)) begin
                        ph_cnt <= '0;
                        state  <= ST_CAPTURE;
                    end else begin
                        ph_cnt <= ph_cnt + PH_W'(1);
                    end
                end
                ST_CAPTURE: begin
                    // Shift in from the top so the first sample ends up in bit 0.
                    m_data <= {dec_out, m_data[FRAME_DATA-1:1]};
                    if (ph_cnt == PH_W'(FRAME_DATA - 1)) begin
                        ph_cnt  <= '0;
                        m_valid <= 1'b1;
                        state   <= ST_HOLD;
                    end else begin
                        ph_cnt <= ph_cnt + PH_W'(1);
                    end
                end
                ST_HOLD: begin
                    if (m_ready) begin
                        m_valid   <= 1'b0;
                        busy      <= 1'b0;
                        frame_cnt <= frame_cnt + CNT_W'(1);
                        state     <= ST_IDLE;
                    end
                end
                default: state <= ST_SYNC;
            endcase
        end
    end

endmodule
